// File: rtl/bus_op_sequencer.sv
// bus_op_sequencer: command-driven bus/register sequencer (LOAD/MOVE/SWAP/CLEAR over four registers plus temp)
module bus_op_sequencer #(
  parameter int n = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic [1:0]   Rx,
  input  logic [1:0]   Ry,
  input  logic [n-1:0] Data,
  output logic [n-1:0] BusWires,
  output logic         Busy,
  output logic         Done,
  output logic [n-1:0] R0,
  output logic [n-1:0] R1,
  output logic [n-1:0] R2,
  output logic [n-1:0] R3
);
  typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;
  localparam logic [1:0] LOAD = 2'd0, MOVE = 2'd1, SWAP = 2'd2;
  state_t state, state_nx;
  logic [1:0] op_q, rx_q, ry_q;
  logic [n-1:0] data_q, t;
  logic [n-1:0] r [4];
  logic [3:0] r_ld;
  logic t_ld;
  logic accept;
  assign accept = state == IDLE && Start;
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (Start ? S1 : IDLE) :
               state == S1   ? (op_q == SWAP ? S2 : IDLE) :
               state == S2   ? S3 : IDLE;
  always_comb begin
    Busy = state != IDLE;
    Done = (state == S1 && op_q != SWAP) || state == S3;
    BusWires = state == S1 ? (op_q == LOAD ? data_q : op_q == MOVE ? r[ry_q] : op_q == SWAP ? r[rx_q] : '0) :
               state == S2 ? r[ry_q] :
               state == S3 ? t : '0;
    t_ld = state == S1 && op_q == SWAP;
    // SWAP S3 writes the second operand; every other load targets the first
    r_ld = (state == S1 && op_q != SWAP) || state == S2 ? 4'b0001 << rx_q :
           state == S3 ? 4'b0001 << ry_q : 4'b0000;
  end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      op_q <= '0;
      rx_q <= '0;
      ry_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_q <= Op;
      rx_q <= Rx;
      ry_q <= Ry;
      data_q <= Data;
    end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      r <= '{default: '0};
      t <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (r_ld[i]) r[i] <= BusWires;
      if (t_ld) t <= BusWires;
    end
  assign R0 = r[0];
  assign R1 = r[1];
  assign R2 = r[2];
  assign R3 = r[3];
endmodule

// File: tb/tb_bus_op_sequencer.sv
// tb_bus_op_sequencer: randomized command stream against a per-command register-bank model
module tb_bus_op_sequencer;
  logic Clock = 0, Resetn = 0, Start = 0;
  logic [1:0] Op = 0, Rx = 0, Ry = 0;
  logic [7:0] Data = 0;
  logic [7:0] BusWires, R0, R1, R2, R3;
  logic Busy, Done;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] m [4];
  bus_op_sequencer #(.n(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Op(Op), .Rx(Rx), .Ry(Ry), .Data(Data),
    .BusWires(BusWires), .Busy(Busy), .Done(Done), .R0(R0), .R1(R1), .R2(R2), .R3(R3)
  );
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] rd(input int k);
    return k == 0 ? R0 : k == 1 ? R1 : k == 2 ? R2 : R3;
  endfunction
  task automatic chk_regs(input string tag);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_R%0d", tag, k), 32'(rd(k)), 32'(m[k]));
  endtask
  task automatic scramble();
    Op = 2'($urandom_range(0, 3));
    Rx = 2'($urandom_range(0, 3));
    Ry = 2'($urandom_range(0, 3));
    Data = 8'($urandom_range(0, 255));
  endtask
  // Called in an IDLE cycle just after an edge; leaves the bench in the IDLE cycle after Done.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] rx, input logic [1:0] ry,
                        input logic [7:0] d, input bit hold);
    logic [7:0] seq[$];
    logic [7:0] nx [4];
    chk("idle_busy", 32'(Busy), 0);
    chk("idle_done", 32'(Done), 0);
    chk("idle_bus", 32'(BusWires), 0);
    chk_regs("idle");
    nx = m;
    case (op)
      2'd0: begin seq = {d}; nx[rx] = d; end
      2'd1: begin seq = {m[ry]}; nx[rx] = m[ry]; end
      2'd2: begin seq = {m[rx], m[ry], m[rx]}; nx[rx] = m[ry]; nx[ry] = m[rx]; end
      default: begin seq = {8'h00}; nx[rx] = 8'h00; end
    endcase
    Start = 1; Op = op; Rx = rx; Ry = ry; Data = d;
    @(posedge Clock); #1;
    foreach (seq[i]) begin
      chk("busy", 32'(Busy), 1);
      chk("done", 32'(Done), 32'(i == seq.size() - 1));
      chk($sformatf("bus_op%0d_step%0d", op, i + 1), 32'(BusWires), 32'(seq[i]));
      if (i == 0) chk_regs("step1");
      scramble();
      Start = hold || (i < seq.size() - 1 && $urandom_range(0, 1) == 1);
      @(posedge Clock); #1;
    end
    m = nx;
    if (!hold) Start = 0;
  endtask
  task automatic idle_cyc();
    Start = 0;
    scramble();
    @(posedge Clock); #1;
    chk("wait_busy", 32'(Busy), 0);
    chk_regs("wait");
  endtask
  initial begin
    m = '{default: 8'h00};
    #3;
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_bus", 32'(BusWires), 0);
    chk_regs("rst");
    #9 Resetn = 1;
    @(posedge Clock); #1;
    do_cmd(2'd0, 2'd2, 2'd0, 8'hA5, 0);
    do_cmd(2'd0, 2'd1, 2'd0, 8'h3C, 0);
    do_cmd(2'd3, 2'd3, 2'd0, 8'hFF, 0);
    do_cmd(2'd1, 2'd3, 2'd1, 8'h77, 0);
    do_cmd(2'd0, 2'd0, 2'd0, 8'h11, 0);
    do_cmd(2'd0, 2'd3, 2'd0, 8'h22, 0);
    do_cmd(2'd2, 2'd0, 2'd3, 8'h00, 0);
    idle_cyc();
    do_cmd(2'd2, 2'd1, 2'd2, 8'h99, 1);
    do_cmd(2'd0, 2'd0, 2'd0, 8'h5A, 1);
    do_cmd(2'd1, 2'd2, 2'd0, 8'h00, 0);
    do_cmd(2'd2, 2'd2, 2'd2, 8'h00, 0);
    do_cmd(2'd3, 2'd1, 2'd3, 8'hEE, 0);
    do_cmd(2'd1, 2'd2, 2'd2, 8'h00, 0);
    idle_cyc();
    // abort a SWAP while it sits in its second step
    Start = 1; Op = 2'd2; Rx = 2'd0; Ry = 2'd2;
    @(posedge Clock); #1;
    Start = 0;
    @(posedge Clock); #1;
    chk("mid_busy", 32'(Busy), 1);
    chk("mid_done", 32'(Done), 0);
    #2 Resetn = 0;
    #1;
    m = '{default: 8'h00};
    chk("abort_busy", 32'(Busy), 0);
    chk("abort_done", 32'(Done), 0);
    chk("abort_bus", 32'(BusWires), 0);
    chk_regs("abort");
    @(posedge Clock); #1;
    chk("abort_hold_done", 32'(Done), 0);
    @(negedge Clock);
    Resetn = 1;
    @(posedge Clock); #1;
    do_cmd(2'd0, 2'd3, 2'd0, 8'hC3, 0);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 5) == 0) idle_cyc();
      do_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
    end
    do_cmd(2'd2, 2'd3, 2'd1, 8'h00, 0);
    idle_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
